// File: rtl/div_unit_pkg.sv
// Shared definitions for the radix-2 restoring divider: FSM state encodings,
// result-ready levels, and the decoder ALU-op codes for DIV/DIVU.
package div_unit_pkg;

   localparam int DivWidth = 32;

   typedef enum logic [1:0] {
      DivFree   = 2'b00,
      DivByZero = 2'b01,
      DivOn     = 2'b10,
      DivEnd    = 2'b11
   } divState_t;

   localparam logic DivResultReady    = 1'b1;
   localparam logic DivResultNotReady = 1'b0;

   localparam logic [7:0] AluOpDiv  = 8'b0001_1010;
   localparam logic [7:0] AluOpDivu = 8'b0001_1011;

endpackage

// File: rtl/div_unit_if.sv
// Execute-stage <-> divider handshake: operands and control from the pipeline,
// result, ready pulse and stall request back.
interface div_unit_if #(parameter int WIDTH = 32);
   logic               start;
   logic               signed_div;
   logic [WIDTH-1:0]   opdata1;
   logic [WIDTH-1:0]   opdata2;
   logic               annul;
   logic [2*WIDTH-1:0] result;
   logic               ready;
   logic               div_stall;

   modport master (
      output start, signed_div, opdata1, opdata2, annul,
      input  result, ready, div_stall
   );

   modport slave (
      input  start, signed_div, opdata1, opdata2, annul,
      output result, ready, div_stall
   );
endinterface

// File: rtl/div_unit.sv
// Multi-cycle MIPS DIV/DIVU unit: one restoring step per cycle over a 65-bit
// {rem, quo} shift register, returning {remainder, quotient} for HI/LO.
module div_unit
   import div_unit_pkg::*;
#(
   parameter int WIDTH = DivWidth
) (
   input logic       clk,
   input logic       resetn,
   div_unit_if.slave divBus
);

   // state     | meaning
   // DivFree   | idle, waiting for start & ~annul
   // DivByZero | divisor was zero; working register forced to 0
   // DivOn     | one restoring step per cycle, cnt = 0..WIDTH-1
   // DivEnd    | ready pulse, signed fix-up applied to result

   divState_t          state;
   divState_t          nextState;
   logic [5:0]         cnt;
   logic [2*WIDTH:0]   work;
   logic [WIDTH-1:0]   divisor;
   logic               signedOp;
   logic               signA;
   logic               signB;

   logic               startReq;
   logic [WIDTH-1:0]   magA;
   logic [WIDTH-1:0]   magB;
   logic [2*WIDTH:0]   shifted;
   logic [WIDTH:0]     diff;
   logic [2*WIDTH:0]   stepped;
   logic [WIDTH-1:0]   quoRaw;
   logic [WIDTH-1:0]   remRaw;
   logic               unusedRemMsb;

   assign startReq = divBus.start & ~divBus.annul;

   assign magA = (divBus.signed_div & divBus.opdata1[WIDTH-1]) ? -divBus.opdata1 : divBus.opdata1;
   assign magB = (divBus.signed_div & divBus.opdata2[WIDTH-1]) ? -divBus.opdata2 : divBus.opdata2;

   // Restoring step: subtract from the shifted partial remainder, keep it only if non-negative.
   assign shifted = {work[2*WIDTH-1:0], 1'b0};
   assign diff    = shifted[2*WIDTH:WIDTH] - {1'b0, divisor};
   assign stepped = diff[WIDTH] ? shifted : {diff, shifted[WIDTH-1:1], 1'b1};

   assign quoRaw       = work[WIDTH-1:0];
   assign remRaw       = work[2*WIDTH-1:WIDTH];
   assign unusedRemMsb = work[2*WIDTH];

   always_ff @(posedge clk) begin
      if (!resetn) begin
         state <= DivFree;
      end else begin
         state <= nextState;
      end
   end

   always_comb begin
      nextState = state;
      if (divBus.annul) begin
         nextState = DivFree;
      end else begin
         case (state)
            DivFree: begin
               if (divBus.start) begin
                  nextState = (divBus.opdata2 == '0) ? DivByZero : DivOn;
               end
            end
            DivByZero: nextState = DivEnd;
            DivOn: begin
               if (cnt == 6'(WIDTH - 1)) begin
                  nextState = DivEnd;
               end
            end
            DivEnd:  nextState = DivFree;
            default: nextState = DivFree;
         endcase
      end
   end

   always_comb begin
      divBus.ready  = DivResultNotReady;
      divBus.result = '0;
      if (state == DivEnd) begin
         divBus.ready  = DivResultReady;
         divBus.result = {(signedOp & signA) ? -remRaw : remRaw,
                          (signedOp & (signA ^ signB)) ? -quoRaw : quoRaw};
      end
      divBus.div_stall = divBus.start & ~divBus.ready & ~divBus.annul;
   end

   always_ff @(posedge clk) begin
      if (!resetn) begin
         cnt      <= '0;
         work     <= '0;
         divisor  <= '0;
         signedOp <= 1'b0;
         signA    <= 1'b0;
         signB    <= 1'b0;
      end else begin
         case (state)
            DivFree: begin
               if (startReq) begin
                  signedOp <= divBus.signed_div;
                  signA    <= divBus.opdata1[WIDTH-1];
                  signB    <= divBus.opdata2[WIDTH-1];
                  work     <= {{(WIDTH+1){1'b0}}, magA};
                  divisor  <= magB;
                  cnt      <= '0;
               end
            end
            DivByZero: begin
               work  <= '0;
               signA <= 1'b0;
               signB <= 1'b0;
            end
            DivOn: begin
               work <= stepped;
               cnt  <= cnt + 6'd1;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_div_unit.sv
// Scoreboard bench for div_unit: directed corner cases plus random DIV/DIVU
// operands checked against a 64-bit arithmetic reference.
module tb_div_unit;
   import div_unit_pkg::*;

   localparam int W = 32;

   typedef struct {
      logic [63:0] res;
      int          cycle;
      string       tag;
   } exp_t;

   logic clk = 1'b0;
   logic resetn = 1'b0;
   int   cyc = 0;
   int   checks = 0;
   int   errors = 0;
   exp_t sbq[$];
   exp_t monExp;

   div_unit_if #(.WIDTH(W)) bus ();

   div_unit #(.WIDTH(W)) dut (
      .clk    (clk),
      .resetn (resetn),
      .divBus (bus)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached, queue size %0d required 0", sbq.size());
      $fatal(1, "watchdog");
   end

   function automatic logic [63:0] refDiv(logic [31:0] a, logic [31:0] b, logic sgn);
      longint sa, sb, q, r;
      if (b == 32'd0) return 64'd0;
      if (sgn) begin
         sa = longint'($signed(a));
         sb = longint'($signed(b));
      end else begin
         sa = longint'({32'd0, a});
         sb = longint'({32'd0, b});
      end
      q = sa / sb;
      r = sa % sb;
      return {r[31:0], q[31:0]};
   endfunction

   task automatic check(string name, logic [63:0] act, logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h required %h", name, act, exp);
      end
   endtask

   always @(negedge clk) begin
      if (resetn && bus.ready) begin
         if (sbq.size() == 0) begin
            check("unexpected_ready", 64'(cyc), 64'hFFFF_FFFF_FFFF_FFFF);
         end else begin
            monExp = sbq.pop_front();
            check({monExp.tag, "_result"}, bus.result, monExp.res);
            check({monExp.tag, "_cycle"}, 64'(cyc), 64'(monExp.cycle));
         end
      end
   end

   task automatic issue(logic [31:0] a, logic [31:0] b, logic sgn, bit push, string tag);
      exp_t e;
      bus.opdata1    = a;
      bus.opdata2    = b;
      bus.signed_div = sgn;
      bus.start      = 1'b1;
      if (push) begin
         e.res   = refDiv(a, b, sgn);
         e.cycle = cyc + ((b == 32'd0) ? 2 : 33);
         e.tag   = tag;
         sbq.push_back(e);
      end
   endtask

   // Waits for ready with a cycle budget; start stays high on return.
   task automatic waitReady(int lat, string tag);
      int n;
      int stallBad = 0;
      bit seen = 0;
      for (n = 0; n <= lat + 5; n++) begin
         @(negedge clk);
         if (bus.ready === 1'b1) begin
            seen = 1;
            break;
         end
         if (bus.div_stall !== 1'b1) stallBad++;
      end
      check({tag, "_latency"}, 64'(n), 64'(lat));
      check({tag, "_stall_busy"}, 64'(stallBad), 64'd0);
      if (seen) check({tag, "_stall_at_ready"}, 64'(bus.div_stall), 64'd0);
      @(posedge clk);
      #1;
   endtask

   task automatic runDiv(logic [31:0] a, logic [31:0] b, logic sgn, string tag);
      issue(a, b, sgn, 1, tag);
      waitReady((b == 32'd0) ? 2 : 33, tag);
   endtask

   task automatic idle(int n);
      bus.start = 1'b0;
      repeat (n) @(posedge clk);
      #1;
   endtask

   initial begin
      int readyCount;
      logic [31:0] ra, rb;
      logic rs;
      bus.start      = 1'b0;
      bus.signed_div = 1'b0;
      bus.opdata1    = '0;
      bus.opdata2    = '0;
      bus.annul      = 1'b0;

      repeat (3) @(posedge clk);
      #1;
      check("rst_ready", 64'(bus.ready), 64'd0);
      check("rst_result", bus.result, 64'd0);
      check("rst_stall_idle", 64'(bus.div_stall), 64'd0);
      check("rst_state", 64'(dut.state), 64'(DivFree));
      bus.start = 1'b1;
      #1;
      check("rst_stall_start", 64'(bus.div_stall), 64'd1);
      bus.start = 1'b0;
      @(posedge clk);
      #1;
      resetn = 1'b1;
      idle(2);

      runDiv(32'd100, 32'd7, 1'b0, "u100_7");
      idle(1);
      runDiv(32'hFFFF_FFF9, 32'd2, 1'b1, "s_m7_2");
      idle(1);
      runDiv(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, "s_min_m1");
      idle(1);
      runDiv(32'd5, 32'd0, 1'b1, "s_5_0");
      idle(1);
      runDiv(32'd5, 32'd0, 1'b0, "u_5_0");
      idle(1);
      runDiv(32'h8000_0000, 32'hFFFF_FFFF, 1'b0, "u_big");
      idle(1);

      runDiv(32'hFFFF_FFFF, 32'd1, 1'b0, "b2b_first");
      runDiv(32'd9, 32'd3, 1'b0, "b2b_second");
      idle(2);

      issue(32'd1000, 32'd3, 1'b0, 0, "annul");
      repeat (10) @(posedge clk);
      #1;
      bus.annul = 1'b1;
      @(negedge clk);
      check("annul_stall", 64'(bus.div_stall), 64'd0);
      check("annul_ready", 64'(bus.ready), 64'd0);
      @(posedge clk);
      #1;
      bus.annul = 1'b0;
      bus.start = 1'b0;
      check("annul_state", 64'(dut.state), 64'(DivFree));
      readyCount = 0;
      repeat (40) begin
         @(negedge clk);
         if (bus.ready === 1'b1) readyCount++;
      end
      check("annul_no_ready", 64'(readyCount), 64'd0);
      check("annul_stall_after", 64'(bus.div_stall), 64'd0);
      @(posedge clk);
      #1;

      issue(32'hFFFF_FF9C, 32'd7, 1'b1, 0, "rstmid");
      repeat (15) @(posedge clk);
      #1;
      resetn = 1'b0;
      @(posedge clk);
      #1;
      resetn = 1'b1;
      check("rstmid_state", 64'(dut.state), 64'(DivFree));
      runDiv(32'hFFFF_FF9C, 32'd7, 1'b1, "rstmid");
      idle(1);

      for (int i = 0; i < 40; i++) begin
         ra = $urandom;
         case ($urandom_range(0, 9))
            0:       rb = 32'd0;
            1, 2:    rb = $urandom_range(1, 15);
            3:       rb = 32'hFFFF_FFFF;
            default: rb = $urandom;
         endcase
         if ($urandom_range(0, 7) == 0) ra = 32'h8000_0000;
         rs = 1'($urandom_range(0, 1));
         runDiv(ra, rb, rs, $sformatf("rand%0d", i));
         if ($urandom_range(0, 1) == 1) idle($urandom_range(1, 3));
      end
      idle(5);

      check("scoreboard_drained", 64'(sbq.size()), 64'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
